// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: register file geometry, ABI register indices
// and the reset values for the stack and global pointers.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam int ZERO = 0;
  localparam int RA   = 1;
  localparam int SP   = 2;
  localparam int GP   = 3;

  localparam logic [31:0] STACK_POINTER_VALUE  = 32'h7FFF_EFFC;
  localparam logic [31:0] GLOBAL_POINTER_VALUE = 32'h1000_8000;

endpackage

// File: rtl/register_en.sv
// Single register with load enable and asynchronous active-high reset to RESET_VALUE.
module register_en #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32-entry integer register file: two combinational read ports, one clocked write port, x0 hardwired to zero.
// Optional same-cycle write-through to the read ports when REG_FILE_BYPASS_EN is defined.
module register_file #(
  parameter int                    DATA_WIDTH           = riscv_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH           = riscv_pkg::ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] STACK_POINTER_VALUE  = riscv_pkg::STACK_POINTER_VALUE,
  parameter logic [DATA_WIDTH-1:0] GLOBAL_POINTER_VALUE = riscv_pkg::GLOBAL_POINTER_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  import riscv_pkg::*;

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // x0 has no storage; the mux input is tied to zero so reads of index 0 are free.
  assign regs[ZERO] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] RST_VAL =
      (i == SP) ? STACK_POINTER_VALUE  :
      (i == GP) ? GLOBAL_POINTER_VALUE : {DATA_WIDTH{1'b0}};

    logic en;
    assign en = Reg_Write_i && (Write_Register_i == ADDR_WIDTH'(i));

    register_en #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RST_VAL)
    ) u_reg (
      .clk (clk),
      .rst (reset),
      .en  (en),
      .d   (Write_Data_i),
      .q   (regs[i])
    );
  end

`ifdef REG_FILE_BYPASS_EN
  logic wr_live;
  assign wr_live = Reg_Write_i && (Write_Register_i != ADDR_WIDTH'(ZERO));

  assign Read_Data_1_o = (wr_live && (Read_Register_1_i == Write_Register_i)) ?
                         Write_Data_i : regs[Read_Register_1_i];
  assign Read_Data_2_o = (wr_live && (Read_Register_2_i == Write_Register_i)) ?
                         Write_Data_i : regs[Read_Register_2_i];
`else
  assign Read_Data_1_o = regs[Read_Register_1_i];
  assign Read_Data_2_o = regs[Read_Register_2_i];
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array model checked every negedge plus directed literal checks.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Reg_Write_i = 1'b0;
  logic [4:0]  Write_Register_i = '0;
  logic [31:0] Write_Data_i = '0;
  logic [4:0]  Read_Register_1_i = '0;
  logic [4:0]  Read_Register_2_i = '0;
  logic [31:0] Read_Data_1_o;
  logic [31:0] Read_Data_2_o;

  int errors = 0;
  int checks = 0;
  bit model_ok = 1'b0;
  logic [31:0] model [32];

  register_file dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o)
  );

  always #5 clk = ~clk;

  // Architectural state: what each register must hold
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
      model[2] = 32'h7FFF_EFFC;
      model[3] = 32'h1000_8000;
      model_ok = 1'b1;
    end else if (Reg_Write_i && Write_Register_i != 5'd0) begin
      model[Write_Register_i] = Write_Data_i;
    end
  end

  function automatic logic [31:0] expect_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (Reg_Write_i && Write_Register_i != 5'd0 && Write_Register_i == ra) return Write_Data_i;
`endif
    return model[ra];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_rd1", Read_Data_1_o, expect_read(Read_Register_1_i));
      chk("model_rd2", Read_Data_2_o, expect_read(Read_Register_2_i));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    Reg_Write_i = we;
    Write_Register_i = wa;
    Write_Data_i = wd;
    Read_Register_1_i = r1;
    Read_Register_2_i = r2;
  endtask

  initial begin
    #1 reset = 1'b1;
    // Reset values visible while reset is held
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1); #1;
    chk("rst_x0", Read_Data_1_o, 32'h0);
    chk("rst_x1", Read_Data_2_o, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3); #1;
    chk("rst_x2", Read_Data_1_o, 32'h7FFF_EFFC);
    chk("rst_x3", Read_Data_2_o, 32'h1000_8000);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31); #1;
    chk("rst_x31", Read_Data_1_o, 32'h0);
    cyc(); cyc();
    reset = 1'b0;

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0); cyc();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5); #1;
    chk("x5_p1", Read_Data_1_o, 32'hDEAD_BEEF);
    chk("x5_p2", Read_Data_2_o, 32'hDEAD_BEEF);
    cyc();

    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0); #1;
    chk("x0_bypass_never", Read_Data_1_o, 32'h0);
    cyc();
    drive(1'b0, 5'd7, 32'h0000_1234, 5'd0, 5'd7); #1;
    chk("x0_after", Read_Data_1_o, 32'h0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7); #1;
    chk("x7_no_we", Read_Data_2_o, 32'h0);
    cyc();

    drive(1'b1, 5'd10, 32'hA5A5_A5A5, 5'd10, 5'd10); #1;
`ifdef REG_FILE_BYPASS_EN
    chk("x10_same_p1", Read_Data_1_o, 32'hA5A5_A5A5);
    chk("x10_same_p2", Read_Data_2_o, 32'hA5A5_A5A5);
`else
    chk("x10_same_p1", Read_Data_1_o, 32'h0);
    chk("x10_same_p2", Read_Data_2_o, 32'h0);
`endif
    cyc();
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd10); #1;
    chk("x10_after_p1", Read_Data_1_o, 32'hA5A5_A5A5);
    chk("x10_after_p2", Read_Data_2_o, 32'hA5A5_A5A5);
    cyc();

    drive(1'b1, 5'd2, 32'h0000_1000, 5'd2, 5'd3); cyc();
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3); #1;
    chk("x2_written", Read_Data_1_o, 32'h0000_1000);
    #1 reset = 1'b1;
    #1;
    chk("x2_mid_reset", Read_Data_1_o, 32'h7FFF_EFFC);
    drive(1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd2); cyc();
    chk("x9_write_in_reset", Read_Data_1_o, 32'h0);
    reset = 1'b0;
    drive(1'b1, 5'd11, 32'h0000_0077, 5'd11, 5'd11);
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("x11_coincident", Read_Data_1_o, 32'h0);
    drive(1'b1, 5'd12, 32'h0000_000C, 5'd12, 5'd11); cyc();
    reset = 1'b0;
    cyc();
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd11); #1;
    chk("x12_post_reset", Read_Data_1_o, 32'h0000_000C);
    chk("x11_lost", Read_Data_2_o, 32'h0);
    cyc();

    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(31 - i));
      cyc();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      Read_Register_1_i = 5'(i);
      Read_Register_2_i = 5'(31 - i);
      #1;
      chk("sweep_p1", Read_Data_1_o, 32'(i) * 32'h0101_0101);
      chk("sweep_p2", Read_Data_2_o, 32'(31 - i) * 32'h0101_0101);
      cyc();
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
